// File: rtl/run_pulse_conditioner.sv
// Run_Accumulate push-button conditioner: 2-FF sync, press/release debounce, one Run_O pulse per press.
// Define AUTO_REPEAT_EN to add auto-repeat pulses while the button is held.
module run_pulse_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic       Clk,
    input  logic       Reset_Clear,
    input  logic       Run_Accumulate,
    output logic       Run_O,
    output logic       Pressed,
    output logic [7:0] Press_Count
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, REL_WAIT} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             sync_p0, btn_s;
    logic             first_pulse, run_next;

    // synchronizer stage: idles high (released)
    always_ff @(posedge Clk or negedge Reset_Clear) begin
        if (!Reset_Clear) begin
            sync_p0 <= 1'b1;
            btn_s   <= 1'b1;
        end else begin
            sync_p0 <= Run_Accumulate;
            btn_s   <= sync_p0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_Clear) begin
        if (!Reset_Clear) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (!btn_s) begin
                    state_next = PRESS_WAIT;
                    cnt_next   = '0;
                end
            end
            PRESS_WAIT: begin
                if (btn_s)                 state_next = IDLE;
                else if (cnt == CNT_LAST)  state_next = HELD;
                else                       cnt_next   = cnt + 1'b1;
            end
            HELD: begin
                if (btn_s) begin
                    state_next = REL_WAIT;
                    cnt_next   = '0;
                end
            end
            REL_WAIT: begin
                if (!btn_s)                state_next = HELD;
                else if (cnt == CNT_LAST)  state_next = IDLE;
                else                       cnt_next   = cnt + 1'b1;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Pressed still low while in HELD marks the first cycle after PRESS_WAIT->HELD
    assign first_pulse = (state == HELD) && !Pressed;

`ifdef AUTO_REPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_DELAY + 1);
    localparam logic [RPT_W-1:0] RPT_FIRE   = RPT_W'(REPEAT_DELAY);
    // reload so that later fires land REPEAT_PERIOD cycles apart
    localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD + 1);

    logic [RPT_W-1:0] rcnt;
    logic             repeat_fire;

    assign repeat_fire = (state == HELD) && (rcnt == RPT_FIRE);

    always_ff @(posedge Clk or negedge Reset_Clear) begin
        if (!Reset_Clear) begin
            rcnt <= '0;
        end else if (state == PRESS_WAIT && state_next == HELD) begin
            rcnt <= '0;
        end else if (state == HELD) begin
            rcnt <= repeat_fire ? RPT_RELOAD : rcnt + 1'b1;
        end
    end

    assign run_next = first_pulse | repeat_fire;
`else
    assign run_next = first_pulse;
`endif

    always_ff @(posedge Clk or negedge Reset_Clear) begin
        if (!Reset_Clear) begin
            Run_O       <= 1'b0;
            Pressed     <= 1'b0;
            Press_Count <= 8'h00;
        end else begin
            Run_O   <= run_next;
            Pressed <= (state == HELD) || (state == REL_WAIT);
            if (run_next) Press_Count <= Press_Count + 8'h01;
        end
    end

endmodule
